// File: rtl/uart_test_rx.sv
// rtl/uart_test_rx.sv - 8N1 UART receiver with 2-flop synchronizer, armed start detect and framing error pulse
module uart_test_rx #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_q, rx_d;
    logic        armed_q, armed_d;
    logic [1:0]  sync_fill_q, sync_fill_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        dv_q, dv_d;
    logic [7:0]  byte_q, byte_d;
    logic        active_q, active_d;
    logic        fe_q, fe_d;

    always_comb begin
        state_d     = state_q;
        rx_meta_d   = i_Rx_Serial;
        rx_d        = rx_meta_q;
        armed_d     = armed_q;
        sync_fill_d = {sync_fill_q[0], 1'b1};
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        dv_d        = 1'b0;
        byte_d      = byte_q;
        fe_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                // The synchronizer's reset value is not line data; only arm once real samples reach rx_q.
                if (rx_q && sync_fill_q[1]) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = 16'd0;
                    state_d = rx_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = 16'd0;
                    shift_d[idx_q] = rx_q;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_CLEANUP;
                    if (rx_q) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        fe_d    = 1'b1;
                        armed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CLEANUP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        active_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_q        <= 1'b1;
            armed_q     <= 1'b0;
            sync_fill_q <= 2'b00;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            dv_q        <= 1'b0;
            byte_q      <= 8'h00;
            active_q    <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_q        <= rx_d;
            armed_q     <= armed_d;
            sync_fill_q <= sync_fill_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            dv_q        <= dv_d;
            byte_q      <= byte_d;
            active_q    <= active_d;
            fe_q        <= fe_d;
        end
    end

    assign o_Rx_DV     = dv_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Rx_Active = active_q;
    assign o_Frame_Err = fe_q;

endmodule

// File: tb/tb_uart_test_rx.sv
// tb/tb_uart_test_rx.sv - directed bench for uart_test_rx at CLKS_PER_BIT=8
module tb_uart_test_rx;

    localparam int C = 8;
    localparam int H = (C - 1) / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic       tx_abort = 1'b0;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Active;
    logic       o_Frame_Err;

    int         n_total = 0;
    int         n_pass = 0;

    int         dv_cnt = 0;
    int         fe_cnt = 0;
    logic [7:0] fe_byte = 8'h00;
    logic [7:0] dv_bytes[$];
    int         run = 0;
    int         last_run = 0;
    int         act_frames = 0;

    uart_test_rx #(.CLKS_PER_BIT(C)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_Serial (rx_line),
        .o_Rx_DV     (o_Rx_DV),
        .o_Rx_Byte   (o_Rx_Byte),
        .o_Rx_Active (o_Rx_Active),
        .o_Frame_Err (o_Frame_Err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_Rx_DV) begin
            dv_cnt = dv_cnt + 1;
            dv_bytes.push_back(o_Rx_Byte);
        end
        if (o_Frame_Err) begin
            fe_cnt  = fe_cnt + 1;
            fe_byte = o_Rx_Byte;
        end
        if (o_Rx_Active) begin
            run = run + 1;
        end else if (run != 0) begin
            last_run   = run;
            run        = 0;
            act_frames = act_frames + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_tally();
        dv_cnt     = 0;
        fe_cnt     = 0;
        fe_byte    = 8'h00;
        dv_bytes.delete();
        run        = 0;
        last_run   = 0;
        act_frames = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        clear_tally();
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            for (int j = 0; j < C; j++) begin
                if (tx_abort) begin
                    rx_line = 1'b1;
                    return;
                end
                tick(1);
            end
        end
    endtask

    initial begin
        logic [8:0] exp_bytes[4];
        logic [8:0] got_b;
        exp_bytes[0] = 9'h000;
        exp_bytes[1] = 9'h0FF;
        exp_bytes[2] = 9'h05A;
        exp_bytes[3] = 9'h081;

        // Reset state
        do_reset();
        chk("rst_dv", o_Rx_DV, 1'b0);
        chk("rst_byte", o_Rx_Byte, 8'h00);
        chk("rst_active", o_Rx_Active, 1'b0);
        chk("rst_fe", o_Frame_Err, 1'b0);

        // Single frame 0xA5
        tick(10);
        send(8'hA5, 1'b1);
        tick(20);
        chk("a5_dv_cnt", dv_cnt, 1);
        chk("a5_byte", o_Rx_Byte, 8'hA5);
        chk("a5_fe_cnt", fe_cnt, 0);
        chk("a5_active_len", last_run, 1 + H + 9 * C);
        chk("a5_frames", act_frames, 1);

        // Back-to-back stream
        do_reset();
        tick(10);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h5A, 1'b1);
        send(8'h81, 1'b1);
        tick(20);
        chk("b2b_dv_cnt", dv_cnt, 4);
        chk("b2b_fe_cnt", fe_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            got_b = (i < dv_bytes.size()) ? {1'b0, dv_bytes[i]} : 9'h1FF;
            chk($sformatf("b2b_byte%0d", i), got_b, exp_bytes[i]);
        end

        // Short glitch rejected, then good frame
        do_reset();
        tick(10);
        rx_line = 1'b0;
        tick(2);
        rx_line = 1'b1;
        tick(20);
        chk("glitch_frames", act_frames, 1);
        chk("glitch_active_len", last_run, H + 1);
        chk("glitch_dv_cnt", dv_cnt, 0);
        chk("glitch_fe_cnt", fe_cnt, 0);
        send(8'h3C, 1'b1);
        tick(20);
        chk("glitch_next_dv", dv_cnt, 1);
        chk("glitch_next_byte", o_Rx_Byte, 8'h3C);

        // Framing error, break hold, recovery
        do_reset();
        tick(10);
        send(8'h3C, 1'b0);
        tick(40);
        chk("fe_hold_active", act_frames, 1);
        rx_line = 1'b1;
        tick(16);
        send(8'hC3, 1'b1);
        tick(20);
        chk("fe_cnt", fe_cnt, 1);
        chk("fe_byte_kept", fe_byte, 8'h00);
        chk("fe_dv_cnt", dv_cnt, 1);
        chk("fe_next_byte", o_Rx_Byte, 8'hC3);
        chk("fe_frames", act_frames, 2);

        // Reset during data bit 4 of 0x96
        do_reset();
        tick(10);
        fork
            send(8'h96, 1'b1);
            begin
                tick(C * 5 + C / 2);
                rst      = 1'b1;
                tx_abort = 1'b1;
                tick(1);
                rst = 1'b0;
                chk("mid_rst_dv", o_Rx_DV, 1'b0);
                chk("mid_rst_active", o_Rx_Active, 1'b0);
                chk("mid_rst_byte", o_Rx_Byte, 8'h00);
                chk("mid_rst_fe", o_Frame_Err, 1'b0);
            end
        join
        tx_abort = 1'b0;
        tick(20);
        send(8'h81, 1'b1);
        tick(20);
        chk("mid_rst_dv_cnt", dv_cnt, 1);
        chk("mid_rst_next_byte", o_Rx_Byte, 8'h81);

        // Line held low through reset release
        rx_line = 1'b0;
        do_reset();
        tick(40);
        chk("low_rel_frames", act_frames, 0);
        chk("low_rel_active", o_Rx_Active, 1'b0);
        chk("low_rel_dv_cnt", dv_cnt, 0);
        rx_line = 1'b1;
        tick(10);
        send(8'h7E, 1'b1);
        tick(20);
        chk("low_rel_next_dv", dv_cnt, 1);
        chk("low_rel_next_byte", o_Rx_Byte, 8'h7E);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
